pixel_packer_mono8: RTL and testbench



---
 rtl/pixel_packer_pkg.sv | 26 ++
 rtl/pixel_packer_mono8_if.sv | 46 ++++
 rtl/byte_accumulator.sv | 27 ++
 rtl/pixel_packer_mono8.sv | 150 +++++++++++++++
 tb/tb_pixel_packer_mono8.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_packer_pkg.sv
// rtl/pixel_packer_pkg.sv - shared constants, state type and tkeep helper for the Mono8 packer
//
// Purpose: word geometry (8-bit pixels, 32 per 256-bit word), the packer FSM
// state type, and keep_mask(n) which returns a mask with the low n bits set.
package pixel_packer_pkg;

  localparam int PIX_W           = 8;
  localparam int PIXELS_PER_WORD = 32;
  localparam int WORD_W          = 256;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH,
    DONE
  } packer_state_t;

  // n ranges 0..32; 32 gives all lanes.
  function automatic logic [PIXELS_PER_WORD-1:0] keep_mask(input logic [5:0] n);
    logic [PIXELS_PER_WORD-1:0] m;
    if (n >= 6'd32) m = '1;
    else            m = (32'd1 << n) - 32'd1;
    return m;
  endfunction

endpackage

// File: rtl/pixel_packer_mono8_if.sv
// rtl/pixel_packer_mono8_if.sv - control handshake plus input/output streams of the Mono8 packer
//
// Purpose: bundles the ap_* control handshake, the 8-bit pixel input stream
// (s_axis_*) and the 256-bit packed output stream (m_axis_*).
// Modports:
//   slave  - the packer's view (takes ap_start, s_axis_tvalid/tdata, m_axis_tready)
//   master - the environment's view (drives those, observes the rest)
// Optional: PACKER_SOF_TUSER_EN adds m_axis_tuser (start-of-frame flag on word 0).
interface pixel_packer_mono8_if;
  import pixel_packer_pkg::*;

  logic                       ap_start;
  logic                       ap_ready;
  logic                       ap_idle;
  logic                       ap_done;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [PIX_W-1:0]           s_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [WORD_W-1:0]          m_axis_tdata;
  logic [PIXELS_PER_WORD-1:0] m_axis_tkeep;
  logic                       m_axis_tlast;
`ifdef PACKER_SOF_TUSER_EN
  logic                       m_axis_tuser;
`endif

  modport slave (
`ifdef PACKER_SOF_TUSER_EN
    output m_axis_tuser,
`endif
    input  ap_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output ap_ready, ap_idle, ap_done, s_axis_tready,
           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport master (
`ifdef PACKER_SOF_TUSER_EN
    input  m_axis_tuser,
`endif
    output ap_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  ap_ready, ap_idle, ap_done, s_axis_tready,
           m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

endinterface

// File: rtl/byte_accumulator.sv
// rtl/byte_accumulator.sv - 32-byte lane accumulator for the Mono8 packer
//
// Purpose: writes din into byte lane `lane` when wr_en is set; clr empties
// the whole vector (clr wins over wr_en).
// Ports: clk, reset (sync, active-high), wr_en, clr, lane[4:0], din[7:0],
//        vec[255:0] (current accumulator contents, unwritten lanes are zero).
module byte_accumulator
  import pixel_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [4:0]        lane,
  input  logic [PIX_W-1:0]  din,
  output logic [WORD_W-1:0] vec
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vec <= '0;
    end else if (wr_en) begin
      vec[{lane, 3'b000} +: PIX_W] <= din;
    end
  end

endmodule

// File: rtl/pixel_packer_mono8.sv
// rtl/pixel_packer_mono8.sv - packs a 1-pixel/cycle Mono8 stream into 256-bit frame-aware words
//
// Purpose: collects OUT_ROWS*OUT_COLS pixels per frame, 32 per output word,
// lane k of a word holding its k-th pixel. The last word of a frame carries
// tlast and a partial tkeep. A frame is started with ap_start; ap_done pulses
// once the tlast word has been accepted downstream.
// Ports: clk, reset (sync, active-high), bus (pixel_packer_mono8_if.slave:
//        ap_start/ap_ready/ap_idle/ap_done, s_axis_* input, m_axis_* output).
// Optional: PACKER_SOF_TUSER_EN drives bus.m_axis_tuser high on word 0 of each frame.
module pixel_packer_mono8
  import pixel_packer_pkg::*;
#(
  parameter int OUT_ROWS = 20,
  parameter int OUT_COLS = 20
) (
  input logic                  clk,
  input logic                  reset,
  pixel_packer_mono8_if.slave  bus
);

  localparam int TOTAL = OUT_ROWS * OUT_COLS;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  packer_state_t ps, ns;

  logic [4:0]                 lane_cnt;
  logic [CNT_W-1:0]           pix_cnt;
  logic                       final_px;
  logic                       last_px;
  logic                       s_ready;
  logic                       accept;
  logic                       load;
  logic                       out_fire;
  logic [WORD_W-1:0]          acc_vec;
  logic [WORD_W-1:0]          word_next;

  logic                       m_tvalid;
  logic [WORD_W-1:0]          m_tdata;
  logic [PIXELS_PER_WORD-1:0] m_tkeep;
  logic                       m_tlast;

  always_comb begin
    last_px  = (pix_cnt == LAST_IDX);
    final_px = (lane_cnt == 5'd31) || last_px;
    out_fire = m_tvalid && bus.m_axis_tready;
    // A word-completing pixel needs the output register free, or freeing this cycle.
    s_ready  = (ps == ACTIVE) && !(final_px && m_tvalid && !bus.m_axis_tready);
    accept   = s_ready && bus.s_axis_tvalid;
    load     = accept && final_px;
  end

  // The completing pixel bypasses the accumulator straight into the output word.
  always_comb begin
    word_next = acc_vec;
    word_next[{lane_cnt, 3'b000} +: PIX_W] = bus.s_axis_tdata;
  end

  byte_accumulator u_acc (
    .clk   (clk),
    .reset (reset),
    .wr_en (accept && !final_px),
    .clr   (load),
    .lane  (lane_cnt),
    .din   (bus.s_axis_tdata),
    .vec   (acc_vec)
  );

  always_ff @(posedge clk) begin
    if (reset) ps <= IDLE;
    else       ps <= ns;
  end

  always_comb begin
    ns           = ps;
    bus.ap_ready = 1'b0;
    bus.ap_idle  = 1'b0;
    bus.ap_done  = 1'b0;
    case (ps)
      IDLE: begin
        bus.ap_ready = 1'b1;
        bus.ap_idle  = 1'b1;
        if (bus.ap_start) ns = ACTIVE;
      end
      ACTIVE: begin
        if (accept && last_px) ns = FLUSH;
      end
      FLUSH: begin
        // The register holds the tlast word from the moment FLUSH is entered.
        if (out_fire && m_tlast) ns = DONE;
      end
      DONE: begin
        bus.ap_done = 1'b1;
        ns          = IDLE;
      end
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt <= '0;
      pix_cnt  <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        lane_cnt <= final_px ? 5'd0 : lane_cnt + 5'd1;
        pix_cnt  <= last_px ? '0 : pix_cnt + CNT_W'(1);
      end
      // Load has priority: a simultaneous drain and reload leaves no bubble.
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= word_next;
        m_tkeep  <= keep_mask({1'b0, lane_cnt} + 6'd1);
        m_tlast  <= last_px;
      end else if (out_fire) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tdata  = m_tdata;
  assign bus.m_axis_tkeep  = m_tkeep;
  assign bus.m_axis_tlast  = m_tlast;

`ifdef PACKER_SOF_TUSER_EN
  logic first_word;
  logic m_tuser;

  // first_word re-arms while idle and drops once word 0 has been loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_word <= 1'b0;
      m_tuser    <= 1'b0;
    end else begin
      if (ps == IDLE) first_word <= 1'b1;
      else if (load)  first_word <= 1'b0;
      if (load) m_tuser <= first_word;
    end
  end

  assign bus.m_axis_tuser = m_tuser;
`endif

endmodule

// File: tb/tb_pixel_packer_mono8.sv
// tb/tb_pixel_packer_mono8.sv - randomized scoreboard bench for pixel_packer_mono8 (64-px and 45-px frames)
module tb_pixel_packer_mono8;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic         sof;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: 4x16 frame (64 px), index 1: 3x15 frame (45 px)
  logic         st[2], iv[2], ordy[2];
  logic [7:0]   idt[2];
  logic         ir[2], ov[2], ol[2], ar[2], ai[2], ad[2], ou[2];
  logic [255:0] od[2];
  logic [31:0]  ok[2];

  pixel_packer_mono8_if ifa ();
  pixel_packer_mono8_if ifb ();

  pixel_packer_mono8 #(.OUT_ROWS(4), .OUT_COLS(16)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  pixel_packer_mono8 #(.OUT_ROWS(3), .OUT_COLS(15)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  assign ifa.ap_start      = st[0];
  assign ifa.s_axis_tvalid = iv[0];
  assign ifa.s_axis_tdata  = idt[0];
  assign ifa.m_axis_tready = ordy[0];
  assign ifb.ap_start      = st[1];
  assign ifb.s_axis_tvalid = iv[1];
  assign ifb.s_axis_tdata  = idt[1];
  assign ifb.m_axis_tready = ordy[1];

  assign ir[0] = ifa.s_axis_tready;  assign ir[1] = ifb.s_axis_tready;
  assign ov[0] = ifa.m_axis_tvalid;  assign ov[1] = ifb.m_axis_tvalid;
  assign od[0] = ifa.m_axis_tdata;   assign od[1] = ifb.m_axis_tdata;
  assign ok[0] = ifa.m_axis_tkeep;   assign ok[1] = ifb.m_axis_tkeep;
  assign ol[0] = ifa.m_axis_tlast;   assign ol[1] = ifb.m_axis_tlast;
  assign ar[0] = ifa.ap_ready;       assign ar[1] = ifb.ap_ready;
  assign ai[0] = ifa.ap_idle;        assign ai[1] = ifb.ap_idle;
  assign ad[0] = ifa.ap_done;        assign ad[1] = ifb.ap_done;
`ifdef PACKER_SOF_TUSER_EN
  assign ou[0] = ifa.m_axis_tuser;   assign ou[1] = ifb.m_axis_tuser;
`else
  assign ou[0] = 1'b0;               assign ou[1] = 1'b0;
`endif

  int    errors = 0;
  int    checks = 0;
  int    dones[2];
  int    lasts[2];
  word_t q0[$];
  word_t q1[$];
  logic  stop_rnd;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input word_t w);
    if (d == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  // Scoreboard: every output handshake is compared with the next model word.
  task automatic mon(input int d);
    word_t e;
    int    sz;
    if (ov[d] && ordy[d]) begin
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk($sformatf("unexpected_word_%0d", d), 256'(sz), 256'(1));
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("tdata_%0d", d), od[d], e.data);
        chk($sformatf("tkeep_%0d", d), 256'(ok[d]), 256'(e.keep));
        chk($sformatf("tlast_%0d", d), 256'(ol[d]), 256'(e.last));
`ifdef PACKER_SOF_TUSER_EN
        chk($sformatf("tuser_%0d", d), 256'(ou[d]), 256'(e.sof));
`endif
        if (ol[d]) lasts[d]++;
      end
    end
    if (ad[d]) dones[d]++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic reset_checks(input int d, input string pfx);
    chk({pfx, "_ap_ready"}, 256'(ar[d]), 256'(1));
    chk({pfx, "_ap_idle"},  256'(ai[d]), 256'(1));
    chk({pfx, "_ap_done"},  256'(ad[d]), 256'(0));
    chk({pfx, "_s_tready"}, 256'(ir[d]), 256'(0));
    chk({pfx, "_m_tvalid"}, 256'(ov[d]), 256'(0));
    chk({pfx, "_m_tdata"},  od[d],       256'(0));
    chk({pfx, "_m_tkeep"},  256'(ok[d]), 256'(0));
    chk({pfx, "_m_tlast"},  256'(ol[d]), 256'(0));
  endtask

  task automatic start(input int d);
    st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target);
    int t = 0;
    while (dones[d] < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("done_count_%0d", d), 256'(dones[d]), 256'(target));
    @(posedge clk); #1;
  endtask

  // mode 0: pixel = index, 1: index+0x80, 2: random. Only words whose pixels
  // are all sent (nsend) are expected.
  task automatic send_frame(input int d, input int n, input int nsend, input int vpct,
                            input int mode, output int stalls);
    logic [7:0] px[$];
    word_t      w;
    int         nw, cnt, t;
    stalls = 0;
    for (int i = 0; i < n; i++)
      px.push_back(mode == 0 ? 8'(i) : mode == 1 ? 8'(i + 128) : 8'($urandom));
    nw = (n + 31) / 32;
    for (int wi = 0; wi < nw; wi++) begin
      cnt = (n - 32 * wi < 32) ? n - 32 * wi : 32;
      if (32 * wi + cnt <= nsend) begin
        w.data = '0;
        for (int k = 0; k < cnt; k++) w.data[8 * k +: 8] = px[32 * wi + k];
        w.keep = (cnt == 32) ? 32'hFFFF_FFFF : (32'd1 << cnt) - 32'd1;
        w.last = (wi == nw - 1);
        w.sof  = (wi == 0);
        push_exp(d, w);
      end
    end
    for (int i = 0; i < nsend; i++) begin
      while ($urandom_range(0, 99) >= vpct) begin
        iv[d] = 1'b0;
        @(posedge clk); #1;
      end
      iv[d]  = 1'b1;
      idt[d] = px[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (ir[d]) break;
        stalls++;
        t++;
        if (t > 1000) begin
          chk("input_accept_timeout", 256'(t), 256'(0));
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    iv[d] = 1'b0;
  endtask

  task automatic hold_output(input int d);
    logic [255:0] cap;
    logic         stable;
    int           t = 0;
    while (!ov[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t3_word0_valid", 256'(ov[d]), 256'(1));
    cap    = od[d];
    stable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (od[d] !== cap || !ov[d]) stable = 1'b0;
    end
    chk("t3_word0_stable", 256'(stable), 256'(1));
    chk("t3_final_px_blocked", 256'({iv[d], ir[d]}), 256'(2'b10));
    @(posedge clk); #1;
    ordy[d] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int stalls;
    rst = 1'b1;
    stop_rnd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; iv[d] = 0; idt[d] = 0; ordy[d] = 1;
      dones[d] = 0; lasts[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_checks(0, "rst_a");
    reset_checks(1, "rst_b");
    rst = 1'b0;
    @(posedge clk); #1;

    // 64-px frame, index pattern, free-flowing output
    start(0);
    send_frame(0, 64, 64, 100, 0, stalls);
    chk("t1_input_stalls", 256'(stalls), 256'(0));
    wait_done(0, 1);
    chk("t1_tlast_count", 256'(lasts[0]), 256'(1));

    // 45-px frame: partial final word
    start(1);
    send_frame(1, 45, 45, 100, 0, stalls);
    wait_done(1, 1);
    chk("t2_tlast_count", 256'(lasts[1]), 256'(1));

    // output back-pressure holds word 0 and blocks the final pixel
    ordy[0] = 1'b0;
    start(0);
    fork
      send_frame(0, 64, 64, 100, 1, stalls);
      hold_output(0);
    join
    chk("t3_stalls_seen", 256'(stalls > 0), 256'(1));
    wait_done(0, 2);

    // three back-to-back random frames with random tvalid/tready
    fork
      begin
        while (!stop_rnd) begin
          @(posedge clk); #1;
          ordy[0] = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int f = 0; f < 3; f++) begin
      start(0);
      chk("t4_busy_not_ready", 256'(ar[0]), 256'(0));
      start(0);
      send_frame(0, 64, 64, 50, 2, stalls);
      wait_done(0, 3 + f);
    end
    stop_rnd = 1'b1;
    @(posedge clk); #2;
    ordy[0] = 1'b1;
    chk("t4_tlast_count", 256'(lasts[0]), 256'(5));

    // reset after 40 of 64 pixels
    start(0);
    send_frame(0, 64, 40, 100, 1, stalls);
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks(0, "t5_rst");
    rst = 1'b0;
    chk("t5_pending_words", 256'(q0.size()), 256'(0));
    @(posedge clk); #1;
    chk("t5_no_done", 256'(dones[0]), 256'(5));
    start(0);
    send_frame(0, 64, 64, 100, 0, stalls);
    wait_done(0, 6);
    chk("t5_tlast_count", 256'(lasts[0]), 256'(6));

    chk("final_queue_a", 256'(q0.size()), 256'(0));
    chk("final_queue_b", 256'(q1.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
